// File: rtl/act_pingpong_buf_pkg.sv
// rtl/act_pingpong_buf_pkg.sv - shared encodings and sizing helpers for the activation ping-pong buffer
package act_pingpong_buf_pkg;

    // Life cycle of one bank: written by DMA, offered to the PE, owned by the PE, returned
    typedef enum logic [1:0] {
        BANK_FREE    = 2'd0,
        BANK_FILLING = 2'd1,
        BANK_FULL    = 2'd2,
        BANK_OWNED   = 2'd3
    } bank_state_t;

    // Writer either waits for its next bank to become free or accepts stream beats
    typedef enum logic {
        WR_WAIT = 1'b0,
        WR_FILL = 1'b1
    } wr_state_t;

    function automatic int calc_dw(input int act_w, input int pack);
        return act_w * pack;
    endfunction

    function automatic int calc_banks(input bit pingpong);
        return pingpong ? 2 : 1;
    endfunction

endpackage

// File: rtl/act_bank_ram.sv
// rtl/act_bank_ram.sv - simple dual-port RAM with registered, reset-to-zero read data
module act_bank_ram #(
    parameter int DW   = 32,
    parameter int AW   = 11,
    parameter int SIZE = 1536
) (
    input  logic          i_clk,
    input  logic          i_rst_n,
    input  logic [AW-1:0] i_wr_addr,
    input  logic          i_wr_ce,
    input  logic          i_wr_we,
    input  logic [DW-1:0] i_wr_d,
    input  logic [AW-1:0] i_rd_addr,
    input  logic          i_rd_ce,
    output logic [DW-1:0] o_rd_q
);

    logic [DW-1:0] r_mem [SIZE];
    logic [DW-1:0] r_q;

    // Storage array is never reset so it can map onto block RAM
    always_ff @(posedge i_clk) begin
        if (i_wr_ce && i_wr_we) begin
            r_mem[i_wr_addr] <= i_wr_d;
        end
    end

    // Read register updates only on a read enable and otherwise holds its last word
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_q <= '0;
        end else if (i_rd_ce) begin
            r_q <= r_mem[i_rd_addr];
        end
    end

    assign o_rd_q = r_q;

endmodule

// File: rtl/act_pingpong_buf.sv
// rtl/act_pingpong_buf.sv - activation pack/fill/handover buffer; ACT_PINGPONG_EN selects two banks
module act_pingpong_buf
    import act_pingpong_buf_pkg::*;
#(
    parameter int ACT_W  = 8,
    parameter int PACK   = 4,
    parameter int DEPTH  = 1536,
    parameter int AWIDTH = 11
) (
    input  logic                  ap_clk,
    input  logic                  ap_rst_n,
    input  logic [AWIDTH:0]       cfg_words,
    input  logic [ACT_W-1:0]      ActDMA_V_V_TDATA,
    input  logic                  ActDMA_V_V_TVALID,
    output logic                  ActDMA_V_V_TREADY,
    output logic                  buf_vld,
    input  logic                  buf_rdy,
    output logic                  buf_bank,
    input  logic                  buf_release,
    input  logic                  rd_ce,
    input  logic [AWIDTH-1:0]     rd_addr,
    output logic [ACT_W*PACK-1:0] rd_q
);

    localparam int DW = calc_dw(ACT_W, PACK);
`ifdef ACT_PINGPONG_EN
    localparam bit PP_EN  = 1'b1;
`else
    localparam bit PP_EN  = 1'b0;
`endif
    localparam int NB     = calc_banks(PP_EN);
    localparam int RAM_AW = PP_EN ? AWIDTH + 1 : AWIDTH;
    localparam int LW     = (PACK > 1) ? $clog2(PACK) : 1;
    localparam int CW     = AWIDTH + 1;

    bank_state_t       r_bstate [2];
    wr_state_t         r_wr_state;
    wr_state_t         w_wr_state_nxt;
    logic              r_wr_bank;
    logic              w_wr_bank_nxt;
    logic              r_tready;
    logic [LW-1:0]     r_lane;
    logic [CW-1:0]     r_wr_cnt;
    logic [CW-1:0]     r_frame_words;
    logic [DW-1:0]     r_word;
    logic              r_own_vld;
    logic              r_own_bank;
    logic              r_offer_bank;

    logic              w_accept;
    logic              w_first;
    logic              w_word_done;
    logic              w_frame_done;
    logic              w_release;
    logic              w_xfer;
    logic              w_other;
    logic              w_wr_bank_free;
    logic [CW-1:0]     w_cfg_words;
    logic [CW-1:0]     w_frame_words;
    logic [CW-1:0]     w_wr_cnt_inc;
    logic [DW-1:0]     w_wdata;
    logic [RAM_AW-1:0] w_wr_addr;
    logic [RAM_AW-1:0] w_rd_addr;

    assign w_accept       = ActDMA_V_V_TVALID && r_tready;
    assign w_first        = w_accept && (r_lane == '0) && (r_wr_cnt == '0);
    assign w_cfg_words    = ((cfg_words == '0) || (cfg_words > CW'(DEPTH))) ? CW'(DEPTH) : cfg_words;
    assign w_frame_words  = w_first ? w_cfg_words : r_frame_words;
    assign w_word_done    = w_accept && (r_lane == LW'(PACK - 1));
    assign w_wr_cnt_inc   = r_wr_cnt + CW'(1);
    assign w_frame_done   = w_word_done && (w_wr_cnt_inc == w_frame_words);
    assign w_release      = buf_release && r_own_vld;
    assign w_xfer         = buf_vld && buf_rdy;
    assign w_other        = PP_EN ? ~r_wr_bank : r_wr_bank;
    // A release landing while waiting frees the bank in time for TREADY one cycle later
    assign w_wr_bank_free = (r_bstate[r_wr_bank] == BANK_FREE) ||
                            (w_release && (r_own_bank == r_wr_bank));

    // Writer next state: pick the alternate bank at frame end, stall until it is free
    always_comb begin
        w_wr_state_nxt = r_wr_state;
        w_wr_bank_nxt  = r_wr_bank;
        case (r_wr_state)
            WR_FILL: begin
                if (w_frame_done) begin
                    w_wr_bank_nxt  = w_other;
                    w_wr_state_nxt = (PP_EN && (r_bstate[w_other] == BANK_FREE)) ? WR_FILL : WR_WAIT;
                end
            end
            WR_WAIT: begin
                if (w_wr_bank_free) begin
                    w_wr_state_nxt = WR_FILL;
                end
            end
            default: w_wr_state_nxt = WR_WAIT;
        endcase
    end

    // Writer state register; TREADY is the registered image of the FILL state
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_wr_state <= WR_FILL;
            r_wr_bank  <= 1'b0;
            r_tready   <= 1'b0;
        end else begin
            r_wr_state <= w_wr_state_nxt;
            r_wr_bank  <= w_wr_bank_nxt;
            r_tready   <= (w_wr_state_nxt == WR_FILL);
        end
    end

    // Lane and word counters; frame length is latched on the first beat of a frame
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_lane        <= '0;
            r_wr_cnt      <= '0;
            r_frame_words <= '0;
        end else begin
            if (w_accept) begin
                r_lane <= w_word_done ? '0 : r_lane + LW'(1);
            end
            if (w_word_done) begin
                r_wr_cnt <= w_frame_done ? '0 : w_wr_cnt_inc;
            end
            if (w_first) begin
                r_frame_words <= w_cfg_words;
            end
        end
    end

    // Lane packing register; lane 0 occupies the least significant bits
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_word <= '0;
        end else begin
            for (int k = 0; k < PACK; k++) begin
                if (w_accept && (r_lane == LW'(k))) begin
                    r_word[k*ACT_W +: ACT_W] <= ActDMA_V_V_TDATA;
                end
            end
        end
    end

    // Completed word merges the beat arriving in the top lane
    always_comb begin
        w_wdata = r_word;
        w_wdata[(PACK-1)*ACT_W +: ACT_W] = ActDMA_V_V_TDATA;
    end

    // Per-bank life cycle; the four events never target the same bank in one cycle
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_bstate[0] <= BANK_FREE;
            r_bstate[1] <= BANK_FREE;
        end else begin
            for (int b = 0; b < 2; b++) begin
                if (w_first && (r_wr_bank == 1'(b))) begin
                    r_bstate[b] <= BANK_FILLING;
                end
                if (w_frame_done && (r_wr_bank == 1'(b))) begin
                    r_bstate[b] <= BANK_FULL;
                end
                if (w_xfer && (r_offer_bank == 1'(b))) begin
                    r_bstate[b] <= BANK_OWNED;
                end
                if (w_release && (r_own_bank == 1'(b))) begin
                    r_bstate[b] <= BANK_FREE;
                end
            end
        end
    end

    // Handover tracking; banks are offered in the same alternating order they were filled
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_own_vld    <= 1'b0;
            r_own_bank   <= 1'b0;
            r_offer_bank <= 1'b0;
        end else begin
            if (w_xfer) begin
                r_own_vld    <= 1'b1;
                r_own_bank   <= r_offer_bank;
                r_offer_bank <= PP_EN ? ~r_offer_bank : r_offer_bank;
            end else if (w_release) begin
                r_own_vld    <= 1'b0;
            end
        end
    end

    assign ActDMA_V_V_TREADY = r_tready;
    assign buf_vld           = !r_own_vld && (r_bstate[r_offer_bank] == BANK_FULL);
    assign buf_bank          = r_own_vld ? r_own_bank : r_offer_bank;

`ifdef ACT_PINGPONG_EN
    assign w_wr_addr = {1'b0, r_wr_cnt[AWIDTH-1:0]} + (r_wr_bank ? RAM_AW'(DEPTH) : '0);
    assign w_rd_addr = {1'b0, rd_addr} + (r_own_bank ? RAM_AW'(DEPTH) : '0);
`else
    assign w_wr_addr = r_wr_cnt[AWIDTH-1:0];
    assign w_rd_addr = rd_addr;
`endif

    act_bank_ram #(
        .DW   (DW),
        .AW   (RAM_AW),
        .SIZE (NB * DEPTH)
    ) u_ram (
        .i_clk     (ap_clk),
        .i_rst_n   (ap_rst_n),
        .i_wr_addr (w_wr_addr),
        .i_wr_ce   (w_word_done),
        .i_wr_we   (1'b1),
        .i_wr_d    (w_wdata),
        .i_rd_addr (w_rd_addr),
        .i_rd_ce   (rd_ce),
        .o_rd_q    (rd_q)
    );

endmodule

// File: tb/tb_act_pingpong_buf.sv
// tb/tb_act_pingpong_buf.sv - self-checking bench for act_pingpong_buf
module tb_act_pingpong_buf;

    localparam int ACT_W  = 8;
    localparam int PACK   = 4;
    localparam int DEPTH  = 8;
    localparam int AWIDTH = 3;
    localparam int DW     = ACT_W * PACK;
`ifdef ACT_PINGPONG_EN
    localparam bit PP = 1'b1;
`else
    localparam bit PP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n = 1'b1;
    logic [AWIDTH:0]   cfg_words = '0;
    logic [ACT_W-1:0]  tdata = '0;
    logic              tvalid = 1'b0;
    logic              tready;
    logic              buf_vld;
    logic              buf_rdy = 1'b0;
    logic              buf_bank;
    logic              buf_release = 1'b0;
    logic              rd_ce = 1'b0;
    logic [AWIDTH-1:0] rd_addr = '0;
    logic [DW-1:0]     rd_q;

    int checks = 0;
    int failures = 0;

    act_pingpong_buf #(
        .ACT_W (ACT_W), .PACK (PACK), .DEPTH (DEPTH), .AWIDTH (AWIDTH)
    ) dut (
        .ap_clk            (clk),
        .ap_rst_n          (rst_n),
        .cfg_words         (cfg_words),
        .ActDMA_V_V_TDATA  (tdata),
        .ActDMA_V_V_TVALID (tvalid),
        .ActDMA_V_V_TREADY (tready),
        .buf_vld           (buf_vld),
        .buf_rdy           (buf_rdy),
        .buf_bank          (buf_bank),
        .buf_release       (buf_release),
        .rd_ce             (rd_ce),
        .rd_addr           (rd_addr),
        .rd_q              (rd_q)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
        end
    endtask

    // Behavioural model: bank ownership as a FIFO of full banks plus expected memory image
    int              m_state [2];   // 0 free, 1 filling, 2 full, 3 owned
    int              m_fullq [$];
    int              m_owned = -1;
    int              m_fill_bank = 0;
    int              m_beat = 0;
    int              m_frame_beats = 0;
    bit              m_tready = 1'b0;
    logic [DW-1:0]   m_mem [2][DEPTH];
    logic [DW-1:0]   m_rdq = '0;
    bit              m_rdq_known = 1'b1;

    always @(posedge clk or negedge rst_n) begin
        int  pre [2];
        int  nxt;
        int  words;
        bit  acc;
        bit  rel;
        bit  xfer;
        if (!rst_n) begin
            m_state[0] = 0; m_state[1] = 0;
            m_fullq.delete();
            m_owned = -1; m_fill_bank = 0; m_beat = 0;
            m_tready = 1'b0; m_rdq = '0; m_rdq_known = 1'b1;
        end else begin
            pre  = m_state;
            acc  = tvalid && m_tready;
            rel  = buf_release && (m_owned >= 0);
            xfer = (m_owned < 0) && (m_fullq.size() > 0) && buf_rdy;
            if (rd_ce) begin
                if (m_owned >= 0) begin
                    m_rdq = m_mem[m_owned][rd_addr];
                    m_rdq_known = 1'b1;
                end else begin
                    m_rdq_known = 1'b0;
                end
            end
            if (acc) begin
                if (m_beat == 0) begin
                    words = ((cfg_words == 0) || (cfg_words > DEPTH)) ? DEPTH : int'(cfg_words);
                    m_frame_beats = words * PACK;
                    m_state[m_fill_bank] = 1;
                end
                m_mem[m_fill_bank][m_beat / PACK][(m_beat % PACK) * ACT_W +: ACT_W] = tdata;
                m_beat++;
                if (m_beat == m_frame_beats) begin
                    m_state[m_fill_bank] = 2;
                    m_fullq.push_back(m_fill_bank);
                    m_beat = 0;
                    nxt = PP ? 1 - m_fill_bank : m_fill_bank;
                    m_fill_bank = nxt;
                    m_tready = (pre[nxt] == 0);
                end
            end else if (!m_tready) begin
                m_tready = (pre[m_fill_bank] == 0) || (rel && (m_owned == m_fill_bank));
            end
            if (xfer) begin
                m_owned = m_fullq.pop_front();
                m_state[m_owned] = 3;
            end
            if (rel) begin
                m_state[m_owned] = 0;
                m_owned = -1;
            end
        end
    end

    // Every-cycle comparison against the model, away from the active edge
    always @(negedge clk) begin
        check("tready", {31'b0, tready}, {31'b0, m_tready});
        check("buf_vld", {31'b0, buf_vld}, {31'b0, (m_owned < 0) && (m_fullq.size() > 0)});
        if (m_owned >= 0)
            check("buf_bank_owned", {31'b0, buf_bank}, m_owned);
        else if (m_fullq.size() > 0)
            check("buf_bank_offer", {31'b0, buf_bank}, m_fullq[0]);
        if (m_rdq_known)
            check("rd_q", rd_q, m_rdq);
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_frame(input int nbeats, input logic [7:0] base, output int stalls);
        int g;
        stalls = 0;
        tvalid = 1'b1;
        for (int i = 0; i < nbeats; i++) begin
            tdata = 8'(base + i);
            g = 0;
            while (!tready && g < 200) begin
                tick;
                g++;
                stalls++;
            end
            if (g >= 200) begin
                checks++;
                failures++;
                $display("FAIL send_timeout actual=stalled required=tready");
                tvalid = 1'b0;
                return;
            end
            tick;
        end
        tvalid = 1'b0;
    endtask

    task automatic accept_bank;
        buf_rdy = 1'b1;
        tick;
        buf_rdy = 1'b0;
    endtask

    task automatic release_bank;
        buf_release = 1'b1;
        tick;
        buf_release = 1'b0;
    endtask

    task automatic read_word(input int addr, output logic [DW-1:0] q);
        rd_ce = 1'b1;
        rd_addr = AWIDTH'(addr);
        tick;
        rd_ce = 1'b0;
        q = rd_q;
    endtask

    initial begin
        #200000;
        failures++;
        $display("FAIL watchdog actual=timeout required=finish");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        logic [DW-1:0] q;
        int st_a;
        int st_b;
        int exp_b;

        // Reset values
        #1 rst_n = 1'b0;
        cfg_words = 4'd3;
        tick; tick;
        check("rst_tready", {31'b0, tready}, 0);
        check("rst_vld", {31'b0, buf_vld}, 0);
        check("rst_bank", {31'b0, buf_bank}, 0);
        check("rst_rdq", rd_q, 0);
        rst_n = 1'b1;
        check("tready_before_edge", {31'b0, tready}, 0);
        tick;
        check("tready_first_edge", {31'b0, tready}, 1);

        // Pack order
        send_frame(12, 8'h01, st_a);
        check("pack_vld", {31'b0, buf_vld}, 1);
        check("pack_bank", {31'b0, buf_bank}, 0);
        check("pack_tready_after", {31'b0, tready}, PP ? 1 : 0);
        accept_bank;
        check("pack_vld_taken", {31'b0, buf_vld}, 0);
        read_word(0, q); check("pack_w0", q, 32'h04030201);
        read_word(1, q); check("pack_w1", q, 32'h08070605);
        read_word(2, q); check("pack_w2", q, 32'h0C0B0A09);
        tick;
        check("rdq_hold", rd_q, 32'h0C0B0A09);
        release_bank;
        check("pack_tready_released", {31'b0, tready}, 1);

        // Handshake hold and spurious release
        exp_b = PP ? 1 : 0;
        send_frame(12, 8'h21, st_a);
        for (int i = 0; i < 10; i++) begin
            tick;
            check("hold_vld", {31'b0, buf_vld}, 1);
            check("hold_bank", {31'b0, buf_bank}, exp_b);
        end
        release_bank;
        check("spurious_vld", {31'b0, buf_vld}, 1);
        check("spurious_bank", {31'b0, buf_bank}, exp_b);
        accept_bank;
        read_word(2, q); check("hold_w2", q, 32'h2C2B2A29);
        release_bank;

        // Overlap (ping-pong) or stall-until-release (single bank)
        if (PP) begin
            send_frame(12, 8'h51, st_a);
            send_frame(12, 8'h61, st_b);
            check("overlap_stalls", st_a + st_b, 0);
            for (int i = 0; i < 3; i++) begin
                check("overlap_tready_low", {31'b0, tready}, 0);
                tick;
            end
            check("overlap_offer0", {31'b0, buf_bank}, 0);
            accept_bank;
            check("overlap_owned_tready", {31'b0, tready}, 0);
            read_word(1, q); check("overlap_a_w1", q, 32'h58575655);
            release_bank;
            check("overlap_release_tready", {31'b0, tready}, 1);
            check("overlap_offer1", {31'b0, buf_bank}, 1);
            accept_bank;
            read_word(0, q); check("overlap_b_w0", q, 32'h64636261);
            release_bank;
        end else begin
            send_frame(12, 8'h51, st_a);
            tvalid = 1'b1;
            for (int i = 0; i < 4; i++) begin
                check("single_tready_low", {31'b0, tready}, 0);
                tick;
            end
            accept_bank;
            check("single_owned_tready", {31'b0, tready}, 0);
            read_word(1, q); check("single_w1", q, 32'h58575655);
            check("single_read_tready", {31'b0, tready}, 0);
            release_bank;
            tvalid = 1'b0;
            check("single_release_tready", {31'b0, tready}, 1);
        end

        // Reset mid-frame
        send_frame(5, 8'h31, st_a);
        rst_n = 1'b0;
        tick;
        check("midrst_tready", {31'b0, tready}, 0);
        check("midrst_vld", {31'b0, buf_vld}, 0);
        rst_n = 1'b1;
        tick;
        check("midrst_tready_up", {31'b0, tready}, 1);
        send_frame(11, 8'h41, st_a);
        check("midrst_no_partial", {31'b0, buf_vld}, 0);
        send_frame(1, 8'h4C, st_a);
        check("midrst_vld", {31'b0, buf_vld}, 1);
        check("midrst_bank", {31'b0, buf_bank}, 0);
        accept_bank;
        read_word(0, q); check("midrst_w0", q, 32'h44434241);
        read_word(2, q); check("midrst_w2", q, 32'h4C4B4A49);
        release_bank;

        // Length edge: zero means full depth
        cfg_words = '0;
        exp_b = PP ? 1 : 0;
        send_frame(DEPTH * PACK - 1, 8'h01, st_a);
        check("len_not_done", {31'b0, buf_vld}, 0);
        send_frame(1, 8'h20, st_a);
        check("len_vld", {31'b0, buf_vld}, 1);
        check("len_bank", {31'b0, buf_bank}, exp_b);
        accept_bank;
        read_word(DEPTH - 1, q); check("len_last", q, 32'h201F1E1D);
        read_word(0, q); check("len_first", q, 32'h04030201);
        release_bank;

        tick; tick;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
